// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and fixed constants.
package ysyx_25040111_ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040111_ifu_pcgen.sv
// Program counter register: redirect target wins over the sequential +4 step.
module ysyx_25040111_ifu_pcgen
  import ysyx_25040111_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_25040111_ifu.sv
// Instruction fetch unit: one outstanding memory request, result held until IDU takes it.
module ysyx_25040111_ifu
  import ysyx_25040111_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_e  state_q, state_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;
  logic [31:0] pc;
  logic        accept;
  logic        handshake;
  logic        redirect_bad;

  assign accept       = imem_req_valid && imem_req_ready;
  assign handshake    = inst_valid_q && inst_ready;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  ysyx_25040111_ifu_pcgen #(
    .RESET_PC(RESET_PC)
  ) u_pcgen (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .advance       ((state_q == HOLD) && handshake),
    .pc            (pc)
  );

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_err_d   = inst_err_q;
    // A stale response retires the drop flag whatever state we are in.
    if (drop_q && imem_resp_valid) begin
      drop_d = 1'b0;
    end
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (accept) begin
          state_d = WAIT;
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (!drop_q && !redirect_valid) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_resp_err ? NOP_INST : imem_resp_data;
            inst_pc_d    = pc;
            inst_err_d   = imem_resp_err;
            state_d      = HOLD;
          end else begin
            state_d = REQ;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (handshake || redirect_valid) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Misaligned targets never reach memory; they surface as a faulting nop.
    if (redirect_bad) begin
      state_d      = HOLD;
      inst_valid_d = 1'b1;
      inst_d       = NOP_INST;
      inst_pc_d    = redirect_pc;
      inst_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
    end
  end

  // A request is held back while a dropped response is still in flight.
  assign imem_req_valid = (state_q == REQ) && !drop_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_err       = inst_err_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Directed bench for the fetch unit: hand-computed expectations for each scenario.
module tb_ysyx_25040111_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  int vectors_applied = 0;
  int miscompares = 0;
  int accept_cnt = 0;
  int xfer_cnt = 0;
  int mark;
  logic saw_stale = 1'b0;

  ysyx_25040111_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Handshake counters and a watch for responses that must never reach IDU.
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) accept_cnt++;
    if (inst_valid && inst_ready) xfer_cnt++;
    if (inst_valid && (inst == 32'hDEAD_BEEF || inst == 32'hCAFE_F00D)) saw_stale = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs for the next cycle, then settle just after the edge.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rdata,
                               input logic rerr, input logic irdy, input logic redv,
                               input logic [31:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rdata;
    imem_resp_err   = rerr;
    inst_ready      = irdy;
    redirect_valid  = redv;
    redirect_pc     = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_inst_err", {31'd0, inst_err}, 32'd0);
    rst_n = 1'b1;
    checkOutput("idle_no_req", {31'd0, imem_req_valid}, 32'd0);

    // Basic zero-wait fetch
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("req1_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("req1_addr", imem_req_addr, 32'h8000_0000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("wait1_no_req", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 1, 32'h0000_0297, 0, 0, 0, 0);
    checkOutput("hold1_valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("hold1_inst", inst, 32'h0000_0297);
    checkOutput("hold1_pc", inst_pc, 32'h8000_0000);
    checkOutput("hold1_err", {31'd0, inst_err}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("xfer1_valid_drop", {31'd0, inst_valid}, 32'd0);
    checkOutput("req2_addr", imem_req_addr, 32'h8000_0004);

    // Back-pressure on the request channel
    mark = accept_cnt;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("bp_addr", imem_req_addr, 32'h8000_0004);
      applyStimulus((i == 4), 0, 0, 0, 0, 0, 0);
    end
    checkOutput("bp_addr_at_accept", imem_req_addr, 32'h8000_0004);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("bp_one_accept", accept_cnt - mark, 32'd1);
    checkOutput("bp_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 1, 32'h0010_0093, 0, 0, 0, 0);
    checkOutput("bp_inst", inst, 32'h0010_0093);
    checkOutput("bp_inst_pc", inst_pc, 32'h8000_0004);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("req3_addr", imem_req_addr, 32'h8000_0008);

    // Redirect while waiting: stale response discarded
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h8000_0100);
    checkOutput("drop_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checkOutput("drop_no_inst", {31'd0, inst_valid}, 32'd0);
    checkOutput("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("drop_req_addr", imem_req_addr, 32'h8000_0100);

    // Held instruction, then redirect with a same-cycle handshake
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h0000_0517, 0, 0, 0, 0);
    mark = xfer_cnt;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_valid", {31'd0, inst_valid}, 32'd1);
      checkOutput("stall_inst", inst, 32'h0000_0517);
      checkOutput("stall_pc", inst_pc, 32'h8000_0100);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h8000_0200);
    checkOutput("redir_xfer_once", xfer_cnt - mark, 32'd1);
    checkOutput("redir_xfer_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("redir_xfer_addr", imem_req_addr, 32'h8000_0200);

    // Misaligned redirect: no memory request, faulting nop
    mark = accept_cnt;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0102);
    checkOutput("mis_no_accept", accept_cnt - mark, 32'd0);
    checkOutput("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("mis_valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("mis_inst", inst, 32'h0000_0013);
    checkOutput("mis_err", {31'd0, inst_err}, 32'd1);
    checkOutput("mis_pc", inst_pc, 32'h8000_0102);

    // Address wrap and error response
    applyStimulus(1, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    checkOutput("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h1234_5678, 1, 0, 0, 0);
    checkOutput("err_valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("err_inst_nop", inst, 32'h0000_0013);
    checkOutput("err_flag", {31'd0, inst_err}, 32'd1);
    checkOutput("err_pc", inst_pc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Redirect in HOLD without handshake kills the instruction
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h0000_0093, 0, 0, 0, 0);
    checkOutput("kill_pre_inst", inst, 32'h0000_0093);
    checkOutput("kill_pre_pc", inst_pc, 32'h0000_0000);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h8000_0300);
    checkOutput("kill_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("kill_addr", imem_req_addr, 32'h8000_0300);

    // Reset with a request outstanding, late response ignored
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    checkOutput("late_resp_no_inst", {31'd0, inst_valid}, 32'd0);
    checkOutput("late_resp_addr", imem_req_addr, 32'h8000_0000);
    applyStimulus(1, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    checkOutput("late_resp_still_none", {31'd0, inst_valid}, 32'd0);
    applyStimulus(1, 1, 32'h0000_0297, 0, 0, 0, 0);
    checkOutput("post_rst_inst", inst, 32'h0000_0297);
    checkOutput("post_rst_pc", inst_pc, 32'h8000_0000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("no_stale_seen", {31'd0, saw_stale}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_ifu.md
YSYX_25040111_IFU -- requirements
Module: ysyx_25040111_ifu

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; every register updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output 32. Together these form the fetch request handshake.
REQ-005 SHALL have ports: imem_resp_valid input 1, imem_resp_data input 32, imem_resp_err input 1. Together these form the fetch response; the responder is always ready.
REQ-006 SHALL have ports: inst_valid output 1, inst_ready input 1, inst output 32, inst_pc output 32, inst_err output 1. Together these form the handshake to IDU.
REQ-007 SHALL have ports: redirect_valid input 1, redirect_pc input 32. Together these form the branch, jump or trap target from the back end.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; at most one request outstanding.
REQ-009 IDLE SHALL last exactly one cycle after reset release, then enter REQ.
REQ-010 REQ SHALL assert imem_req_valid with imem_req_addr = pc, and SHALL hold both stable until imem_req_ready; on the accept edge it SHALL enter WAIT.
REQ-011 In WAIT, imem_resp_valid SHALL capture data into inst, capture pc into inst_pc, capture imem_resp_err into inst_err, and move to HOLD.
REQ-012 In HOLD, inst_valid SHALL be 1 and inst/inst_pc/inst_err SHALL be stable until inst_valid && inst_ready.
REQ-013 A HOLD handshake SHALL set pc = pc + 32'd4 (modulo 2^32; 0xFFFF_FFFC wraps to 0) and SHALL enter REQ the next cycle; fetch-to-IDU latency with a zero-wait memory is 3 cycles (REQ, WAIT, HOLD).
REQ-014 redirect_valid SHALL set pc = redirect_pc in every state. It has priority over pc + 4.
REQ-015 Redirect in REQ, not yet accepted: the next cycle SHALL present the new address (the address may change only in this case).
REQ-016 Redirect in WAIT or on the REQ accept edge: a drop flag SHALL be set, the pending response SHALL be discarded without reaching IDU, and then the block SHALL go to REQ with the new pc.
REQ-017 Redirect in HOLD without a handshake: the held instruction SHALL be killed (inst_valid = 0 next cycle) and the FSM SHALL enter REQ.
REQ-018 Redirect in HOLD with a handshake in the same cycle: the transfer counts, and the next fetch SHALL come from redirect_pc.
REQ-019 A redirect_pc with [1:0] != 0 SHALL NOT issue a memory request. The block SHALL enter HOLD with inst = 32'h0000_0013 (nop), inst_err = 1 and inst_pc = redirect_pc.
REQ-020 A response with imem_resp_err = 1 SHALL be delivered with inst forced to 32'h0000_0013 and inst_err = 1.
REQ-021 imem_resp_valid outside WAIT, with no drop pending, SHALL be ignored.

Reset
REQ-022 While rst_n = 0 on a clock edge: state = IDLE, pc = RESET_PC, drop flag = 0, imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0.
REQ-023 Reset asserted mid-operation SHALL abandon any outstanding request. A response arriving after reset release, before the first REQ accept, SHALL be ignored.

Structure
REQ-024 The shared header SHALL hold the FSM state encodings, the NOP constant 32'h0000_0013 and the RESET_PC default.
REQ-025 The block SHALL be one module. A sub-module ysyx_25040111_ifu_pcgen is permitted; it holds the pc register, the +4 adder and redirect priority.

Verification
REQ-026 Reset, then a zero-wait memory returning 0x00000297 -> request at 0x8000_0000, inst_valid on cycle 3 after IDLE, inst_pc 0x8000_0000, next request 0x8000_0004.
REQ-027 req_ready low for 5 cycles -> addr stable for 5 cycles; exactly one accept.
REQ-028 Redirect to 0x8000_0100 while in WAIT, stale response 0xDEADBEEF -> 0xDEADBEEF is never presented; next request is 0x8000_0100.
REQ-029 HOLD with inst_ready = 0 for 4 cycles, then redirect plus handshake in the same cycle -> one transfer; next address is redirect_pc.
REQ-030 Redirect to 0x8000_0102 -> no memory request; inst = 0x00000013, inst_err = 1, inst_pc = 0x8000_0102.
REQ-031 pc = 0xFFFF_FFFC, handshake -> next request 0x0000_0000; imem_resp_err = 1 -> inst_err = 1.
